// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_pkg
// Brief    : Shared SPI definitions: FSM state encoding, SPI mode constants
//            and the default frame width. Used by master, slave and benches.
// Revision : 1.0 - initial release
// ============================================================================
package spi_pkg;

   // Frame width used when an instance does not override it
   localparam int DATA_W_DEFAULT = 8;

   // SPI mode 1: sclk idles low, data is launched on the rising edge and
   // captured on the falling edge
   localparam logic CPOL = 1'b0;
   localparam logic CPHA = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_HIGH  = 3'd2,
      ST_LOW   = 3'd3,
      ST_HOLD  = 3'd4,
      ST_GAP   = 3'd5
   } spi_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_sclk_gen.sv
`default_nettype none
// ============================================================================
// Module   : spi_sclk_gen
// Brief    : Half-period counter for the SPI master. Counts 0..CLK_DIV-1
//            while enabled, flags the last cycle of each half-period, and
//            owns the registered sclk level plus rise/fall strobes.
// Revision : 1.0 - initial release
// ============================================================================
module spi_sclk_gen
   import spi_pkg::*;
#(
   parameter int CLK_DIV = 5     // half-period in clk cycles, 2 or more
) (
   input  logic clk,
   input  logic reset_n,
   input  logic en,              // counter runs in every non-idle state
   input  logic toggle_en,       // sclk may toggle at the end of this half-period
   output logic sclk,
   output logic half_end,        // last cycle of the current half-period
   output logic rise_stb,        // sclk rises on the coming edge
   output logic fall_stb         // sclk falls on the coming edge
);

   localparam int               CNT_W    = $clog2(CLK_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt;

   assign half_end = en && (cnt == CNT_LAST);
   assign rise_stb = half_end && toggle_en && (sclk == CPOL);
   assign fall_stb = half_end && toggle_en && (sclk != CPOL);

   // Half-period counter: held at zero while idle, wraps at CLK_DIV-1
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (!en || half_end) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // sclk level: returns to idle polarity whenever the counter is disabled
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sclk <= CPOL;
      end else if (!en) begin
         sclk <= CPOL;
      end else if (rise_stb || fall_stb) begin
         sclk <= ~sclk;
      end
   end

endmodule
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
// Module   : spi_master
// Brief    : Mode-1 SPI master, one DATA_W-bit full-duplex frame per start
//            request. Every state other than IDLE lasts one sclk half-period;
//            the trailing GAP keeps cs high for a half-period between frames.
//            A start presented in the last GAP cycle is accepted directly,
//            so back-to-back frames repeat every (2*DATA_W+2)*CLK_DIV cycles.
// Revision : 1.0 - initial release
// ============================================================================
module spi_master
   import spi_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEFAULT,
   parameter int CLK_DIV = 5
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [DATA_W-1:0] tx_data,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] rx_data,
   output logic              sclk,
   output logic              cs,
   output logic              mosi,
   input  logic              miso
);

   localparam int               BIT_W    = $clog2(DATA_W + 1);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

   spi_state_t        state, state_nx;
   logic [DATA_W-1:0] tx_sr, tx_sr_nx;
   logic [DATA_W-1:0] rx_sr, rx_sr_nx;
   logic [DATA_W-1:0] rx_data_nx;
   logic [BIT_W-1:0]  bit_cnt, bit_cnt_nx;
   logic              cs_nx, mosi_nx, busy_nx, done_nx;
   logic              accept;
   logic              gen_en, toggle_en;
   logic              half_end, rise_stb, fall_stb;

   assign gen_en    = (state != ST_IDLE);
   assign toggle_en = (state == ST_SETUP) || (state == ST_HIGH) || (state == ST_LOW);

   spi_sclk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_sclk_gen (
      .clk       (clk),
      .reset_n   (reset_n),
      .en        (gen_en),
      .toggle_en (toggle_en),
      .sclk      (sclk),
      .half_end  (half_end),
      .rise_stb  (rise_stb),
      .fall_stb  (fall_stb)
   );

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state and next-value logic for the frame sequencer
   always_comb begin
      state_nx   = state;
      tx_sr_nx   = tx_sr;
      rx_sr_nx   = rx_sr;
      bit_cnt_nx = bit_cnt;
      cs_nx      = cs;
      mosi_nx    = mosi;
      busy_nx    = busy;
      done_nx    = 1'b0;
      rx_data_nx = rx_data;
      accept     = 1'b0;

      case (state)
         ST_IDLE: begin
            accept = start;
         end
         ST_SETUP, ST_LOW: begin
            // rising sclk launches the next bit, MSB first
            if (rise_stb) begin
               mosi_nx  = tx_sr[DATA_W-1];
               tx_sr_nx = {tx_sr[DATA_W-2:0], 1'b0};
               state_nx = ST_HIGH;
            end
         end
         ST_HIGH: begin
            // falling sclk captures miso; the slave launched it a half-period ago
            if (fall_stb) begin
               rx_sr_nx   = {rx_sr[DATA_W-2:0], miso};
               bit_cnt_nx = bit_cnt + 1'b1;
               state_nx   = (bit_cnt == LAST_BIT) ? ST_HOLD : ST_LOW;
            end
         end
         ST_HOLD: begin
            if (half_end) begin
               cs_nx      = 1'b1;
               mosi_nx    = 1'b0;
               rx_data_nx = rx_sr;
               done_nx    = 1'b1;
               state_nx   = ST_GAP;
            end
         end
         ST_GAP: begin
            if (half_end) begin
               busy_nx  = 1'b0;
               state_nx = ST_IDLE;
               accept   = start;
            end
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase

      // A new frame overrides whatever the idle/gap branch decided
      if (accept) begin
         tx_sr_nx   = tx_data;
         rx_sr_nx   = '0;
         bit_cnt_nx = '0;
         cs_nx      = 1'b0;
         busy_nx    = 1'b1;
         state_nx   = ST_SETUP;
      end
   end

   // Shift registers, bit counter and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_sr   <= '0;
         rx_sr   <= '0;
         bit_cnt <= '0;
         cs      <= 1'b1;
         mosi    <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         rx_data <= '0;
      end else begin
         tx_sr   <= tx_sr_nx;
         rx_sr   <= rx_sr_nx;
         bit_cnt <= bit_cnt_nx;
         cs      <= cs_nx;
         mosi    <= mosi_nx;
         busy    <= busy_nx;
         done    <= done_nx;
         rx_data <= rx_data_nx;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_master
// Brief    : Self-checking bench for spi_master: table of exchanges against a
//            bench-side mode-1 slave, edge-position monitor, start-while-busy,
//            mid-frame reset and a CLK_DIV=2 loopback instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_master;
   import spi_pkg::*;

   localparam int CD  = 5;
   localparam int CD2 = 2;
   localparam int DW  = 8;

   logic       clk      = 1'b0;
   logic       reset_n  = 1'b0;
   logic       start    = 1'b0;
   logic [7:0] tx_data  = '0;
   logic       miso     = 1'b0;
   logic       busy, done, sclk, cs, mosi;
   logic [7:0] rx_data;

   logic       start2   = 1'b0;
   logic [7:0] tx2      = '0;
   logic       busy2, done2, sclk2, cs2, mosi2;
   logic [7:0] rx2;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always #5 clk = ~clk;

   // cycle index: value seen at a negedge is the number of rising edges so far
   always @(posedge clk) cyc <= cyc + 1;

   spi_master #(.DATA_W(DW), .CLK_DIV(CD)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .tx_data(tx_data),
      .busy(busy), .done(done), .rx_data(rx_data),
      .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso)
   );

   spi_master #(.DATA_W(DW), .CLK_DIV(CD2)) dut_lb (
      .clk(clk), .reset_n(reset_n), .start(start2), .tx_data(tx2),
      .busy(busy2), .done(done2), .rx_data(rx2),
      .sclk(sclk2), .cs(cs2), .mosi(mosi2), .miso(mosi2)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Mode-1 slave: loads its byte when cs falls, launches MSB first on rising sclk
   logic [7:0] sl_data = '0;
   logic [7:0] sl_sr   = '0;
   logic [7:0] sl_rx   = '0;
   always @(negedge cs or posedge sclk) begin
      if (!cs && sclk) begin
         miso  <= sl_sr[7];
         sl_sr <= {sl_sr[6:0], 1'b0};
      end else if (!cs) begin
         sl_sr <= sl_data;
      end
   end

   // Slave capture on falling sclk
   always @(negedge sclk) if (!cs) sl_rx <= {sl_rx[6:0], mosi};

   // Edge-position monitor on the CLK_DIV=5 instance
   logic       mon_en    = 1'b0;
   logic [7:0] exp_tx    = '0;
   logic       prev_cs   = 1'b1;
   logic       prev_sclk = 1'b0;
   logic       prev_mosi = 1'b0;
   logic [7:0] mosi_bits = '0;
   int         rises     = 0;
   int         low_start = 0;
   int         cs_falls  = 0;
   always @(negedge clk) begin
      if (mon_en && reset_n) begin
         if (!prev_cs && !cs && (mosi !== prev_mosi))
            check("mosi_on_rise", {31'd0, sclk && !prev_sclk}, 32'd1);
         if (sclk && !prev_sclk) begin
            rises++;
            mosi_bits = {mosi_bits[6:0], mosi};
         end
         if (prev_cs && !cs) begin
            low_start = cyc;
            rises     = 0;
            cs_falls++;
         end
         if (!prev_cs && cs) begin
            check("cs_low_len", cyc - low_start, (2 * DW + 1) * CD);
            check("sclk_rises", rises, DW);
            check("mosi_seq", {24'd0, mosi_bits}, {24'd0, exp_tx});
         end
      end
      prev_cs   = cs;
      prev_sclk = sclk;
      prev_mosi = mosi;
   end

   // Reference model: a full-duplex exchange swaps the two bytes, and the
   // frame timeline follows from the half-period count
   typedef struct {
      logic [7:0] tx;
      logic [7:0] slv;
      logic [7:0] exp_rx;
      logic [7:0] exp_sl;
   } vec_t;

   function automatic vec_t model(input logic [7:0] t, input logic [7:0] s);
      vec_t v;
      v.tx     = t;
      v.slv    = s;
      v.exp_rx = s;
      v.exp_sl = t;
      return v;
   endfunction

   localparam int DONE_EDGE = (2 * DW + 1) * CD;
   localparam int BUSY_EDGE = (2 * DW + 2) * CD;

   task automatic run_frame(input logic [7:0] t, input logic [7:0] s,
                            output logic [7:0] got_rx, output logic [7:0] got_sl,
                            output int done_at, output int done_n, output int busy_end);
      int c0;
      sl_data = s;
      exp_tx  = t;
      @(negedge clk);
      start   = 1'b1;
      tx_data = t;
      @(negedge clk);
      start   = 1'b0;
      tx_data = 8'($urandom_range(0, 255));
      c0      = cyc;
      check("accept_busy", {31'd0, busy}, 32'd1);
      check("accept_cs", {31'd0, cs}, 32'd0);
      done_n   = 0;
      done_at  = -1;
      busy_end = -1;
      for (int k = 0; k < 400; k++) begin
         if (done) begin
            done_n++;
            if (done_at < 0) done_at = cyc - c0;
         end
         if (!busy) begin
            busy_end = cyc - c0;
            break;
         end
         @(negedge clk);
      end
      got_rx = rx_data;
      got_sl = sl_rx;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: time limit reached with total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t       vecs[$];
      logic [7:0] g_rx, g_sl;
      int         d_at, d_n, b_end, dn, f0;
      logic [7:0] lb_vals[3];
      int         fall_t[3];
      int         done_t;
      logic       found, prev;

      // ---------------- reset state ----------------
      repeat (3) @(negedge clk);
      check("rst_cs", {31'd0, cs}, 32'd1);
      check("rst_sclk", {31'd0, sclk}, 32'd0);
      check("rst_mosi", {31'd0, mosi}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_rx_data", {24'd0, rx_data}, 32'd0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_cs", {31'd0, cs}, 32'd1);
      check("idle_busy", {31'd0, busy}, 32'd0);
      mon_en = 1'b1;

      // ---------------- table of exchanges ----------------
      vecs.push_back('{8'hAC, 8'hA5, 8'hA5, 8'hAC});
      vecs.push_back('{8'h00, 8'hFF, 8'hFF, 8'h00});
      vecs.push_back('{8'hFF, 8'h00, 8'h00, 8'hFF});
      vecs.push_back('{8'h80, 8'h01, 8'h01, 8'h80});
      vecs.push_back('{8'h01, 8'h80, 8'h80, 8'h01});
      for (int i = 0; i < 6; i++)
         vecs.push_back(model(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))));

      for (int i = 0; i < vecs.size(); i++) begin
         run_frame(vecs[i].tx, vecs[i].slv, g_rx, g_sl, d_at, d_n, b_end);
         check("rx_data", {24'd0, g_rx}, {24'd0, vecs[i].exp_rx});
         check("slave_rx", {24'd0, g_sl}, {24'd0, vecs[i].exp_sl});
         check("done_edge", d_at, DONE_EDGE);
         check("done_width", d_n, 1);
         check("busy_fall_edge", b_end, BUSY_EDGE);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      // ---------------- start while busy ----------------
      sl_data = 8'h3C;
      exp_tx  = 8'hC3;
      f0      = cs_falls;
      @(negedge clk);
      start   = 1'b1;
      tx_data = 8'hC3;
      @(negedge clk);
      start   = 1'b0;
      repeat (19) @(negedge clk);
      start   = 1'b1;
      tx_data = 8'h33;
      @(negedge clk);
      start   = 1'b0;
      dn = 0;
      for (int k = 0; k < 250; k++) begin
         @(negedge clk);
         if (done) dn++;
      end
      check("busy_start_dones", dn, 1);
      check("busy_start_frames", cs_falls - f0, 1);
      check("busy_start_rx", {24'd0, rx_data}, 32'h3C);
      check("busy_start_slave", {24'd0, sl_rx}, 32'hC3);
      check("busy_start_idle", {31'd0, busy}, 32'd0);

      // ---------------- reset mid-frame ----------------
      sl_data = 8'h5A;
      exp_tx  = 8'hFF;
      @(negedge clk);
      start   = 1'b1;
      tx_data = 8'hFF;
      @(negedge clk);
      start   = 1'b0;
      repeat (2 * 4 * CD + 2) @(negedge clk);
      check("pre_rst_cs", {31'd0, cs}, 32'd0);
      check("pre_rst_mosi", {31'd0, mosi}, 32'd1);
      mon_en = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      check("async_rst_cs", {31'd0, cs}, 32'd1);
      check("async_rst_sclk", {31'd0, sclk}, 32'd0);
      check("async_rst_mosi", {31'd0, mosi}, 32'd0);
      check("async_rst_busy", {31'd0, busy}, 32'd0);
      check("async_rst_done", {31'd0, done}, 32'd0);
      check("async_rst_rx", {24'd0, rx_data}, 32'd0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      dn = 0;
      for (int k = 0; k < 120; k++) begin
         @(negedge clk);
         if (done) dn++;
      end
      check("rst_no_done", dn, 0);
      check("rst_rx_kept_zero", {24'd0, rx_data}, 32'd0);
      mon_en = 1'b1;
      run_frame(8'h96, 8'h69, g_rx, g_sl, d_at, d_n, b_end);
      check("post_rst_rx", {24'd0, g_rx}, 32'h69);
      check("post_rst_slave", {24'd0, g_sl}, 32'h96);
      check("post_rst_done_edge", d_at, DONE_EDGE);

      // ---------------- loopback, CLK_DIV=2, back-to-back ----------------
      lb_vals[0] = 8'h00;
      lb_vals[1] = 8'hFF;
      lb_vals[2] = 8'h5A;
      done_t = 0;
      @(negedge clk);
      start2 = 1'b1;
      tx2    = lb_vals[0];
      for (int i = 0; i < 3; i++) begin
         found = 1'b0;
         prev  = cs2;
         for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk);
            if (prev && !cs2) found = 1'b1;
            prev = cs2;
         end
         check("lb_accept", {31'd0, found}, 32'd1);
         fall_t[i] = cyc;
         if (i < 2) tx2 = lb_vals[i+1];
         else start2 = 1'b0;
         if (i > 0) begin
            check("lb_spacing", fall_t[i] - fall_t[i-1], (2 * DW + 2) * CD2);
            check("lb_cs_gap", {31'd0, (fall_t[i] - done_t) >= CD2}, 32'd1);
         end
         found = 1'b0;
         for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk);
            if (done2) found = 1'b1;
         end
         check("lb_done_seen", {31'd0, found}, 32'd1);
         done_t = cyc;
         check("lb_rx", {24'd0, rx2}, {24'd0, lb_vals[i]});
         check("lb_done_edge", done_t - fall_t[i], (2 * DW + 1) * CD2);
      end
      repeat (2 * (2 * DW + 2) * CD2) @(negedge clk);
      check("lb_idle", {31'd0, busy2}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/spi_master.md
# spi_master

Mode-1 (CPOL=0, CPHA=1) SPI master, one 8-bit frame per request. Sits directly upstream of `spi_slave`: it generates `sclk`, `cs` and `mosi` for the slave and captures its `miso`. A system-side request/done handshake exchanges one byte in each direction per frame. All SPI outputs are registered and derived from the single system clock.

## Interface
- `DATA_W`, 8: frame length in bits, sent MSB first.
- `CLK_DIV`, 5: `sclk` half-period in `clk` cycles. Legal values are 2 and above.
- `clk` in 1: system clock. Every register updates on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: frame request. Sampled only while `busy`=0.
- `tx_data` in DATA_W: byte to transmit. Latched on the accepted `start`.
- `busy` out 1: high from the accepted `start` through the end of the inter-frame gap.
- `done` out 1: one-cycle pulse when `rx_data` is updated.
- `rx_data` out DATA_W: last received frame. Holds its value until the next `done`.
- `sclk` out 1: SPI clock. Idles low.
- `cs` out 1: chip select, active low. Idles high.
- `mosi` out 1: serial data to the slave.
- `miso` in 1: serial data from the slave.

## Operation
- **States:** IDLE, SETUP, HIGH, LOW, HOLD, GAP. One half-period counter runs 0..CLK_DIV-1. Every non-IDLE state lasts exactly CLK_DIV cycles.
- **IDLE:** `cs`=1, `sclk`=0, `busy`=0.
  - On `start`=1: load `tx_data` into the TX shift register, clear the bit counter, drive `cs`=0 and `busy`=1, then go to SETUP.
- **SETUP → HIGH:** drive `sclk` 0→1 and `mosi` = TX[MSB], then shift TX left.
- **HIGH:**
  - At the end of the half-period, drive `sclk` 1→0 and shift `miso` into the RX register at the LSB. Increment the bit count.
  - If bits remain, go to LOW. Otherwise go to HOLD.
- **LOW → HIGH:** drive `sclk` 0→1 and `mosi` = next TX bit.
- **HOLD → GAP:**
  - Drive `cs`=1 and copy the RX register to `rx_data`.
  - Assert `done` for one cycle.
  - `mosi` is held at the last bit, then driven to 0 in GAP.
- **GAP → IDLE:** `busy` drops on this transition. This guarantees `cs` stays high for at least CLK_DIV cycles between frames.
- **Sampling:** `miso` is sampled without a synchronizer. The slave updates `miso` on the rising `sclk` edge, which is CLK_DIV `clk` cycles before the master samples it on the falling edge.
- **`start` while `busy`=1:** ignored and not queued. `tx_data` changes during a frame have no effect.
- **Reset, including mid-frame:** `cs`=1, `sclk`=0, `mosi`=0, `busy`=0, `done`=0, `rx_data`=0, state=IDLE, all counters and shift registers cleared. A partial frame is discarded and raises no `done`.

## Timing
- Let edge 0 be the `clk` edge at which `start` is accepted.
- `cs` falls and `busy` rises at edge 0.
- Rising `sclk` edges occur at CLK_DIV·(1+2k), for k = 0..DATA_W-1.
- Falling `sclk` edges occur at CLK_DIV·(2+2k).
- The last fall is at 2·DATA_W·CLK_DIV (edge 16·CLK_DIV for 8 bits).
- `cs` rises, `rx_data` updates and `done` rises all at edge (2·DATA_W+1)·CLK_DIV, which is 17·CLK_DIV for 8 bits. `done` falls one cycle later.
- `busy` falls at (2·DATA_W+2)·CLK_DIV. The next `start` can be accepted on that same edge.
- Back-to-back frame period: (2·DATA_W+2)·CLK_DIV. With the defaults this is 90 `clk` cycles.
- `sclk` duty cycle is exactly 50%. The first rising edge of `sclk` follows the fall of `cs` by CLK_DIV cycles, and `cs` rises CLK_DIV cycles after the last falling edge of `sclk`.

## Structure
- Shared package `spi_pkg`:
  - state enumeration
  - CPOL/CPHA constants (mode 1)
  - default DATA_W
- The package is reused by `spi_slave` and by the benches.
- One sub-module, `spi_sclk_gen`: the half-period counter. It takes CLK_DIV plus an enable and outputs the `sclk` level and one-cycle `rise_stb`/`fall_stb` strobes.
- The FSM and shift registers remain in `spi_master`.

## Test plan
- **Master to `spi_slave`:** slave `data_in`=8'hA5, `start` with `tx_data`=8'hAC → slave `data_out`=8'hAC, master `rx_data`=8'hA5, `done` high for exactly one cycle at edge 17·CLK_DIV.
- **Loopback (`miso`=`mosi`), CLK_DIV=2:** send 8'h00, 8'hFF, 8'h5A back-to-back → each `rx_data` equals its `tx_data`, `start`-to-`start` spacing is 36 cycles, and `cs` is high for at least 2 cycles between frames.
- **Edge-position checker:** every `mosi` change coincides with a rising `sclk` edge, `cs` low spans exactly 17·CLK_DIV cycles, and `sclk` produces exactly 8 rising edges per frame.
- **`start` while busy:** pulse `start` with 8'h33 at edge 20 of a frame sending 8'hC3 → only 8'hC3 appears on `mosi`, no second frame starts, and only one `done` is raised.
- **Reset mid-frame:** assert `reset_n`=0 after 4 bits → outputs reach their reset values without waiting for a `clk` edge, there is no `done`, and `rx_data`=0. The next frame completes correctly.
